poly_edge_sequencer: RTL and testbench

- Collects 16-bit coordinate words from the SPI slave receiver into a vertex buffer, one CS frame per polygon.
- At frame end, drives the shared line rasteriser one edge at a time over a start/done handshake.
- Sits between the SPI word receiver and the line drawer inside Main; it is the only master of the line drawer.

---
 rtl/poly_edge_sequencer_if.sv | 46 ++++
 rtl/poly_edge_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_poly_edge_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_edge_sequencer_if.sv
// ---------------------------------------------------------------------------
// poly_edge_sequencer_if
//   Bundles the SPI-word input side and the line-drawer handshake of
//   poly_edge_sequencer into one interface.
//
//   Parameters:
//     CORDW : coordinate / word width in bits
//
//   Signals:
//     io_word, io_word_valid, io_frame_end : from the SPI word receiver
//     io_line_start, io_line_x0/y0/x1/y1   : edge command to the line drawer
//     io_line_done                         : edge completion from the drawer
//     io_busy, io_overflow, io_edges_drawn : status
//
//   Modports:
//     slave  : the sequencer side
//     master : the environment (receiver + drawer) side
// ---------------------------------------------------------------------------
interface poly_edge_sequencer_if #(
    parameter int CORDW = 16
) ();
    logic [CORDW-1:0] io_word;
    logic             io_word_valid;
    logic             io_frame_end;
    logic             io_line_start;
    logic [CORDW-1:0] io_line_x0;
    logic [CORDW-1:0] io_line_y0;
    logic [CORDW-1:0] io_line_x1;
    logic [CORDW-1:0] io_line_y1;
    logic             io_line_done;
    logic             io_busy;
    logic             io_overflow;
    logic [7:0]       io_edges_drawn;

    modport slave (
        input  io_word, io_word_valid, io_frame_end, io_line_done,
        output io_line_start, io_line_x0, io_line_y0, io_line_x1, io_line_y1,
        output io_busy, io_overflow, io_edges_drawn
    );

    modport master (
        output io_word, io_word_valid, io_frame_end, io_line_done,
        input  io_line_start, io_line_x0, io_line_y0, io_line_x1, io_line_y1,
        input  io_busy, io_overflow, io_edges_drawn
    );
endinterface

// File: rtl/poly_edge_sequencer.sv
// ---------------------------------------------------------------------------
// poly_edge_sequencer
//   Collects x/y coordinate words (one CS frame per polygon) into a vertex
//   buffer and, when the frame closes, feeds the line drawer one edge at a
//   time over a start/done handshake.
//
//   Optional feature macro: POLY_CLOSE_EN
//     defined   : n>=3 vertices draw n edges (closing edge n-1 -> 0)
//     undefined : n>=3 vertices draw n-1 edges (open polyline)
//     two vertices always draw exactly one edge.
//
//   Parameters:
//     CORDW     : coordinate / word width
//     MAX_VERTS : vertex buffer depth (>= 2)
//
//   Ports:
//     clock : system clock
//     reset : synchronous, active-low reset
//     bus   : poly_edge_sequencer_if.slave (word input, drawer handshake,
//             status outputs)
// ---------------------------------------------------------------------------
module poly_edge_sequencer #(
    parameter int CORDW     = 16,
    parameter int MAX_VERTS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    poly_edge_sequencer_if.slave  bus
);
    localparam int CW = $clog2(MAX_VERTS + 1);   // vertex count width
    localparam int IW = $clog2(MAX_VERTS);       // buffer index width
    localparam logic [CW:0] TWO_EXT = 2;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t state_reg, state_next;

    // vertex buffer: written only while collecting, no reset needed
    logic [CORDW-1:0] x_mem [MAX_VERTS];
    logic [CORDW-1:0] y_mem [MAX_VERTS];

    logic [CW-1:0]    vcnt_reg;
    logic             phase_reg;        // 1 = pending x latched, waiting for y
    logic [CORDW-1:0] pend_x_reg;
    logic [CW-1:0]    edge_reg;         // index of edge currently in flight
    logic [CW-1:0]    n_edges_reg;
    logic [CORDW-1:0] x0_reg, y0_reg, x1_reg, y1_reg;
    logic             overflow_reg;
    logic [7:0]       drawn_reg;

    // ---------------------------------------------------------------------
    // Event decode
    // ---------------------------------------------------------------------
    logic          word_in_collect;
    logic          completes;
    logic          room;
    logic          store;
    logic [CW-1:0] vcnt_eff;
    logic          frame_close;
    logic          start_draw;
    logic          trailing_x;
    logic          ovf_event;
    logic          done_in_wait;
    logic          last_edge;
    logic [CW:0]   end_idx;
    logic [CORDW-1:0] v1_x, v1_y;

    function automatic logic [CW-1:0] edges_for(input logic [CW-1:0] n);
        logic [CW-1:0] r;
        if (n == CW'(2)) begin
            r = CW'(1);
        end else begin
`ifdef POLY_CLOSE_EN
            r = n;
`else
            r = n - CW'(1);
`endif
        end
        return r;
    endfunction

    always_comb begin
        word_in_collect = (state_reg == ST_COLLECT) && bus.io_word_valid;
        completes       = word_in_collect && phase_reg;
        room            = (vcnt_reg < CW'(MAX_VERTS));
        store           = completes && room;
        vcnt_eff        = vcnt_reg + CW'(store);
        frame_close     = (state_reg == ST_COLLECT) && bus.io_frame_end;
        start_draw      = frame_close && (vcnt_eff >= CW'(2));
        // an x left without its y once this cycle's word (if any) is counted
        trailing_x      = frame_close && (word_in_collect ? !phase_reg : phase_reg);
        ovf_event       = (completes && !room) || trailing_x ||
                          (bus.io_word_valid && (state_reg != ST_COLLECT));
        done_in_wait    = (state_reg == ST_WAIT) && bus.io_line_done;
        last_edge       = ((edge_reg + CW'(1)) == n_edges_reg);

        // end vertex of the following edge; wraps to vertex 0 for the
        // closing edge
        end_idx = {1'b0, edge_reg} + TWO_EXT;
        if (end_idx == {1'b0, vcnt_reg}) begin
            end_idx = '0;
        end

        // vertex 1 may be completed by the very word that arrives with
        // frame_end, so bypass the buffer in that case
        if (store && (vcnt_reg == CW'(1))) begin
            v1_x = pend_x_reg;
            v1_y = bus.io_word;
        end else begin
            v1_x = x_mem[1];
            v1_y = y_mem[1];
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bus.io_line_start = 1'b0;
        bus.io_busy       = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                if (start_draw) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.io_line_start = 1'b1;
                bus.io_busy       = 1'b1;
                state_next        = ST_WAIT;
            end
            ST_WAIT: begin
                bus.io_busy = 1'b1;
                if (bus.io_line_done) begin
                    state_next = last_edge ? ST_COLLECT : ST_ISSUE;
                end
            end
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Vertex buffer write
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (store) begin
            x_mem[vcnt_reg[IW-1:0]] <= pend_x_reg;
            y_mem[vcnt_reg[IW-1:0]] <= bus.io_word;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            vcnt_reg     <= '0;
            phase_reg    <= 1'b0;
            pend_x_reg   <= '0;
            edge_reg     <= '0;
            n_edges_reg  <= '0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            overflow_reg <= 1'b0;
            drawn_reg    <= '0;
        end else begin
            if (ovf_event) begin
                overflow_reg <= 1'b1;
            end

            if (word_in_collect) begin
                if (!phase_reg) begin
                    pend_x_reg <= bus.io_word;
                    phase_reg  <= 1'b1;
                end else begin
                    phase_reg <= 1'b0;
                    if (store) begin
                        vcnt_reg <= vcnt_reg + CW'(1);
                    end
                end
            end

            if (frame_close) begin
                phase_reg <= 1'b0;
                if (start_draw) begin
                    vcnt_reg    <= vcnt_eff;
                    edge_reg    <= '0;
                    n_edges_reg <= edges_for(vcnt_eff);
                    drawn_reg   <= '0;
                    x0_reg      <= x_mem[0];
                    y0_reg      <= y_mem[0];
                    x1_reg      <= v1_x;
                    y1_reg      <= v1_y;
                end else begin
                    vcnt_reg <= '0;
                end
            end

            if (done_in_wait) begin
                drawn_reg <= drawn_reg + 8'd1;
                if (last_edge) begin
                    vcnt_reg <= '0;
                end else begin
                    // next edge starts where the current one ended
                    edge_reg <= edge_reg + CW'(1);
                    x0_reg   <= x1_reg;
                    y0_reg   <= y1_reg;
                    x1_reg   <= x_mem[end_idx[IW-1:0]];
                    y1_reg   <= y_mem[end_idx[IW-1:0]];
                end
            end
        end
    end

    assign bus.io_line_x0     = x0_reg;
    assign bus.io_line_y0     = y0_reg;
    assign bus.io_line_x1     = x1_reg;
    assign bus.io_line_y1     = y1_reg;
    assign bus.io_overflow    = overflow_reg;
    assign bus.io_edges_drawn = drawn_reg;

endmodule

// File: tb/tb_poly_edge_sequencer.sv
module tb_poly_edge_sequencer;
    localparam int MAXV = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    poly_edge_sequencer_if #(.CORDW(16)) bus ();

    poly_edge_sequencer #(.CORDW(16), .MAX_VERTS(MAXV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
    } seg_t;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    int   vx[$];
    int   vy[$];
    int   pend_m;
    bit   phase_m;
    bit   busy_m;
    bit   ovf_m;
    int   drawn_m;
    int   ne_m;
    bit   start_due;
    seg_t cur_m;
    seg_t exp_q[$];
    seg_t log_q[$];

    function automatic logic [63:0] pack(input seg_t s);
        return {s.x0[15:0], s.y0[15:0], s.x1[15:0], s.y1[15:0]};
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        vx.delete();
        vy.delete();
        pend_m    = 0;
        phase_m   = 1'b0;
        busy_m    = 1'b0;
        ovf_m     = 1'b0;
        drawn_m   = 0;
        ne_m      = 0;
        start_due = 1'b0;
        cur_m     = '{0, 0, 0, 0};
        exp_q.delete();
    endfunction

    // applies the rules to one sampled cycle: word first, then frame end, then done
    function automatic void model_update(input bit wv, input int w, input bit fe, input bit dn);
        bit b;
        int n;
        int ne;
        b = busy_m;
        if (wv) begin
            if (b) begin
                ovf_m = 1'b1;
            end else if (!phase_m) begin
                pend_m  = w;
                phase_m = 1'b1;
            end else begin
                phase_m = 1'b0;
                if (vx.size() < MAXV) begin
                    vx.push_back(pend_m);
                    vy.push_back(w);
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        if (fe && !b) begin
            if (phase_m) begin
                ovf_m   = 1'b1;
                phase_m = 1'b0;
            end
            n = vx.size();
            if (n >= 2) begin
`ifdef POLY_CLOSE_EN
                ne = (n == 2) ? 1 : n;
`else
                ne = n - 1;
`endif
                for (int e = 0; e < ne; e++) begin
                    exp_q.push_back('{vx[e], vy[e], vx[(e + 1) % n], vy[(e + 1) % n]});
                end
                busy_m    = 1'b1;
                drawn_m   = 0;
                ne_m      = ne;
                start_due = 1'b1;
            end
            vx.delete();
            vy.delete();
        end
        if (dn && b) begin
            drawn_m++;
            if (drawn_m == ne_m) busy_m = 1'b0;
            else start_due = 1'b1;
        end
    endfunction

    // compare process: every cycle, mid-period
    always @(negedge clock) begin
        if (chk_en) begin
            seg_t act;
            act = '{int'(bus.io_line_x0), int'(bus.io_line_y0),
                    int'(bus.io_line_x1), int'(bus.io_line_y1)};
            check("line_start", 64'(bus.io_line_start), 64'(start_due));
            if (bus.io_line_start === 1'b1) begin
                $display("edge start: (%0d,%0d)-(%0d,%0d)", act.x0, act.y0, act.x1, act.y1);
                log_q.push_back(act);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 64'd1, 64'd0);
                end else begin
                    cur_m = exp_q.pop_front();
                    check("edge_coords", pack(act), pack(cur_m));
                end
            end else if (busy_m) begin
                check("coords_held", pack(act), pack(cur_m));
            end
            start_due = 1'b0;
            check("busy", 64'(bus.io_busy), 64'(busy_m));
            check("overflow", 64'(bus.io_overflow), 64'(ovf_m));
            check("edges_drawn", 64'(bus.io_edges_drawn), 64'(drawn_m));
        end
    end

    // all tasks are entered and left 1 time unit after a rising edge
    task automatic apply(input bit wv, input int w, input bit fe, input bit dn);
        bus.io_word       = w[15:0];
        bus.io_word_valid = wv;
        bus.io_frame_end  = fe;
        bus.io_line_done  = dn;
        @(posedge clock);
        model_update(wv, w, fe, dn);
        #1;
        bus.io_word_valid = 1'b0;
        bus.io_frame_end  = 1'b0;
        bus.io_line_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send(input int w);
        apply(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic frame_end();
        apply(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        reset = 1'b1;
        log_q.delete();
    endtask

    // drawer responder, bounded by the model's own edge count
    task automatic draw_all(input int gap);
        int guard = 0;
        while (busy_m && guard < 20) begin
            idle(gap);
            apply(1'b0, 0, 1'b0, 1'b1);
            guard++;
        end
    endtask

    function automatic void check_log(input string name, input int idx, input seg_t exp);
        if (idx < log_q.size()) check(name, pack(log_q[idx]), pack(exp));
        else check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    endfunction

    initial begin
        reset             = 1'b0;
        bus.io_word       = '0;
        bus.io_word_valid = 1'b0;
        bus.io_frame_end  = 1'b0;
        bus.io_line_done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // reset state
        check("rst_outputs", {bus.io_line_x0, bus.io_line_y0, bus.io_line_x1, bus.io_line_y1}, 64'd0);
        check("rst_status", {61'd0, bus.io_line_start, bus.io_busy, bus.io_overflow}, 64'd0);

        // square
        do_reset();
        send(0); send(0); send(0); send(100); send(100); send(100); send(100); send(0);
        frame_end();
        draw_all(2);
        idle(2);
        check_log("square_e0", 0, '{0, 0, 0, 100});
        check_log("square_e2", 2, '{100, 100, 100, 0});
`ifdef POLY_CLOSE_EN
        check("square_count", 64'(log_q.size()), 64'd4);
        check("square_drawn", 64'(bus.io_edges_drawn), 64'd4);
        check_log("square_e3", 3, '{100, 0, 0, 0});
`else
        check("square_count", 64'(log_q.size()), 64'd3);
        check("square_drawn", 64'(bus.io_edges_drawn), 64'd3);
`endif

        // offset square
        do_reset();
        send(1); send(0); send(1); send(100); send(101); send(100); send(101); send(0);
        frame_end();
        draw_all(1);
        idle(2);
        check_log("offset_e2", 2, '{101, 100, 101, 0});
`ifdef POLY_CLOSE_EN
        check("offset_count", 64'(log_q.size()), 64'd4);
`else
        check("offset_count", 64'(log_q.size()), 64'd3);
        check("offset_drawn", 64'(bus.io_edges_drawn), 64'd3);
`endif

        // single vertex frame
        do_reset();
        send(5); send(7);
        frame_end();
        idle(4);
        check("short_count", 64'(log_q.size()), 64'd0);
        check("short_busy", 64'(bus.io_busy), 64'd0);
        check("short_ovf", 64'(bus.io_overflow), 64'd0);

        // trailing unpaired x
        log_q.delete();
        send(1); send(2); send(3); send(4); send(9);
        frame_end();
        draw_all(1);
        idle(2);
        check("trail_count", 64'(log_q.size()), 64'd1);
        check_log("trail_e0", 0, '{1, 2, 3, 4});
        check("trail_ovf", 64'(bus.io_overflow), 64'd1);

        // words while waiting on the drawer
        do_reset();
        send(0); send(0); send(10); send(0); send(10); send(10);
        frame_end();
        idle(1);
        send(55); send(66);
        idle(1);
        check("abuse_ovf", 64'(bus.io_overflow), 64'd1);
        draw_all(1);
        idle(2);
        check_log("abuse_e0", 0, '{0, 0, 10, 0});

        // buffer overflow: 10 pairs into 8 slots
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(i * 3);
            send(i * 5 + 1);
        end
        frame_end();
        draw_all(1);
        idle(2);
        check("full_ovf", 64'(bus.io_overflow), 64'd1);
`ifdef POLY_CLOSE_EN
        check("full_drawn", 64'(bus.io_edges_drawn), 64'd8);
        check_log("full_last", 7, '{21, 36, 0, 1});
`else
        check("full_drawn", 64'(bus.io_edges_drawn), 64'd7);
        check_log("full_last", 6, '{18, 31, 21, 36});
`endif

        // reset during the second wait
        do_reset();
        send(0); send(0); send(0); send(100); send(100); send(100); send(100); send(0);
        frame_end();
        idle(1);
        apply(1'b0, 0, 1'b0, 1'b1);
        idle(1);
        reset = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        reset = 1'b1;
        check("midrst_coords", {bus.io_line_x0, bus.io_line_y0, bus.io_line_x1, bus.io_line_y1}, 64'd0);
        check("midrst_status", {53'd0, bus.io_edges_drawn, bus.io_line_start, bus.io_busy, bus.io_overflow}, 64'd0);
        apply(1'b0, 0, 1'b0, 1'b1);
        idle(3);
        check("midrst_starts", 64'(log_q.size()), 64'd2);

        // last y together with frame end
        do_reset();
        send(7); send(8); send(9);
        apply(1'b1, 10, 1'b1, 1'b0);
        draw_all(1);
        idle(2);
        check("coinc_count", 64'(log_q.size()), 64'd1);
        check_log("coinc_e0", 0, '{7, 8, 9, 10});

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
